wb_master_engine: RTL

//  Wishbone classic single-transfer bus master: the initiator end of wb_slave_if.

---
 rtl/wb_master_engine.sv | 120 ++++++++++++
 1 files changed

// File: rtl/wb_master_engine.sv
// wb_master_engine: Wishbone classic single-transfer master with RTY retries and STB timeout.
module wb_master_engine #(
  parameter int ADDR_W    = 32,
  parameter int DATA_W    = 32,
  parameter int SEL_W     = 4,
  parameter int TAG_W     = 16,
  parameter int MAX_RETRY = 3,
  parameter int TIMEOUT   = 255
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              cmd_valid,
  output logic              cmd_ready,
  input  logic              cmd_we,
  input  logic [ADDR_W-1:0] cmd_adr,
  input  logic [DATA_W-1:0] cmd_dat,
  input  logic [SEL_W-1:0]  cmd_sel,
  input  logic [TAG_W-1:0]  cmd_tga,
  input  logic [TAG_W-1:0]  cmd_tgc,
  input  logic [TAG_W-1:0]  cmd_tgd,
  input  logic              cmd_lock,
  output logic              rsp_valid,
  output logic [1:0]        rsp_status,
  output logic [DATA_W-1:0] rsp_dat,
  output logic [TAG_W-1:0]  rsp_tgd,
  output logic              CYC_O,
  output logic              STB_O,
  output logic              WE_O,
  output logic              LOCK_O,
  output logic [ADDR_W-1:0] ADR_O,
  output logic [DATA_W-1:0] DAT_O,
  output logic [SEL_W-1:0]  SEL_O,
  output logic [TAG_W-1:0]  TGA_O,
  output logic [TAG_W-1:0]  TGC_O,
  output logic [TAG_W-1:0]  TGD_O,
  input  logic [DATA_W-1:0] DAT_I,
  input  logic [TAG_W-1:0]  TGD_I,
  input  logic              ACK_I,
  input  logic              ERR_I,
  input  logic              RTY_I
);
  typedef enum logic [1:0] {IDLE, BUS, BACKOFF, RESP} state_t;
  state_t      state, state_nxt;
  logic [31:0] retry_cnt, wait_cnt;
  logic [1:0]  status_nxt;
  logic        accept, latch_rd, fin;
  assign cmd_ready = (state == IDLE) && rst;
  assign accept    = cmd_valid && cmd_ready;
  assign fin       = (state == BUS) && (state_nxt == RESP);
  always_comb begin
    state_nxt  = state;
    status_nxt = 2'b00;
    latch_rd   = 1'b0;
    case (state)
      IDLE:    state_nxt = accept ? BUS : IDLE;
      BUS:
        if (CYC_O && ERR_I) begin
          state_nxt  = RESP;
          status_nxt = 2'b01;
        end else if (CYC_O && RTY_I) begin
          state_nxt  = (retry_cnt < 32'(MAX_RETRY)) ? BACKOFF : RESP;
          status_nxt = 2'b10;
        end else if (CYC_O && ACK_I) begin
          state_nxt = RESP;
          latch_rd  = !WE_O;
        end else if (TIMEOUT != 0 && wait_cnt == 32'(TIMEOUT - 1)) begin
          state_nxt  = RESP;
          status_nxt = 2'b11;
        end
      BACKOFF: state_nxt = BUS;
      default: state_nxt = IDLE;
    endcase
  end
  always_ff @(posedge clk or negedge rst)
    if (!rst) state <= IDLE;
    else      state <= state_nxt;
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      CYC_O      <= 1'b0;
      STB_O      <= 1'b0;
      WE_O       <= 1'b0;
      LOCK_O     <= 1'b0;
      ADR_O      <= '0;
      DAT_O      <= '0;
      SEL_O      <= '0;
      TGA_O      <= '0;
      TGC_O      <= '0;
      TGD_O      <= '0;
      rsp_valid  <= 1'b0;
      rsp_status <= 2'b00;
      rsp_dat    <= '0;
      rsp_tgd    <= '0;
      retry_cnt  <= '0;
      wait_cnt   <= '0;
    end else begin
      if (accept) begin
        WE_O  <= cmd_we;
        ADR_O <= cmd_adr;
        DAT_O <= cmd_dat;
        SEL_O <= cmd_sel;
        TGA_O <= cmd_tga;
        TGC_O <= cmd_tgc;
        TGD_O <= cmd_tgd;
      end
      CYC_O     <= (state_nxt == BUS) || (state_nxt == BACKOFF);
      STB_O     <= state_nxt == BUS;
      LOCK_O    <= accept ? cmd_lock : (state_nxt == RESP ? 1'b0 : LOCK_O);
      rsp_valid <= state_nxt == RESP;
      retry_cnt <= accept ? '0 : ((state == BUS && state_nxt == BACKOFF) ? retry_cnt + 1 : retry_cnt);
      // wait_cnt counts STB-high edges of the current attempt only
      wait_cnt  <= (accept || state == BACKOFF) ? '0 :
                   ((state == BUS && state_nxt == BUS) ? wait_cnt + 1 : wait_cnt);
      if (fin) begin
        rsp_status <= status_nxt;
        rsp_dat    <= latch_rd ? DAT_I : '0;
        rsp_tgd    <= latch_rd ? TGD_I : '0;
      end
    end
  end
endmodule
